// File: rtl/target_encoder.sv
// target_encoder: writable 16-entry target table with a sequential reverse
// lookup. A search walks the table one entry per cycle, starting at index 0,
// and reports the lowest index whose valid entry equals the requested target.
module target_encoder #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 10
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Clear,
    input  logic          WrEn,
    input  logic [AW-1:0] WrAddr,
    input  logic [DW-1:0] WrData,
    input  logic [AW-1:0] RdAddr,
    output logic [DW-1:0] RdTarget,
    input  logic          ReqValid,
    output logic          ReqReady,
    input  logic [DW-1:0] ReqTarget,
    output logic          ResValid,
    input  logic          ResReady,
    output logic [AW-1:0] ResAddr,
    output logic          ResHit
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] entry_data [DEPTH];
    logic [DEPTH-1:0] entry_vld;
    logic [AW-1:0] ptr;
    logic [DW-1:0] tgt;
    logic [AW-1:0] res_addr;
    logic          res_hit;
    logic          cur_match;
    logic          last;

    // Compare against registered contents, so a write landing this edge is
    // only visible to entries the pointer has not reached yet.
    assign cur_match = entry_vld[ptr] && (entry_data[ptr] == tgt);
    assign last      = (ptr == AW'(DEPTH - 1));

    // Readback is independent of the search and has no latency.
    assign RdTarget = entry_vld[RdAddr] ? entry_data[RdAddr] : '0;
    assign ResAddr  = res_addr;
    assign ResHit   = res_hit;

    // Table storage: Clear first, then the write, so a same-cycle write survives.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            entry_vld <= '0;
            for (int i = 0; i < DEPTH; i++) entry_data[i] <= '0;
        end else begin
            if (Clear) entry_vld <= '0;
            if (WrEn) begin
                entry_data[WrAddr] <= WrData;
                entry_vld[WrAddr]  <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        ReqReady  = 1'b0;
        ResValid  = 1'b0;
        case (state)
            IDLE: begin
                ReqReady = 1'b1;
                if (ReqValid) state_nxt = SCAN;
            end
            SCAN: begin
                if (cur_match || last) state_nxt = DONE;
            end
            DONE: begin
                ResValid = 1'b1;
                if (ResReady) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Search datapath: latch target, advance pointer, capture the result.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr      <= '0;
            tgt      <= '0;
            res_addr <= '0;
            res_hit  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        tgt <= ReqTarget;
                        ptr <= '0;
                    end
                end
                SCAN: begin
                    if (cur_match) begin
                        res_addr <= ptr;
                        res_hit  <= 1'b1;
                    end else if (last) begin
                        res_addr <= '0;
                        res_hit  <= 1'b0;
                    end else begin
                        ptr <= ptr + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_target_encoder.sv
// Self-checking bench for target_encoder: directed plan steps followed by
// randomized table loads and searches, checked against a table model.
module tb_target_encoder;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 10;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          Clear;
    logic          WrEn;
    logic [AW-1:0] WrAddr;
    logic [DW-1:0] WrData;
    logic [AW-1:0] RdAddr;
    logic [DW-1:0] RdTarget;
    logic          ReqValid;
    logic          ReqReady;
    logic [DW-1:0] ReqTarget;
    logic          ResValid;
    logic          ResReady;
    logic [AW-1:0] ResAddr;
    logic          ResHit;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference table
    logic [DW-1:0] m_data [DEPTH];
    bit            m_vld  [DEPTH];

    target_encoder #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Clear(Clear), .WrEn(WrEn),
        .WrAddr(WrAddr), .WrData(WrData), .RdAddr(RdAddr), .RdTarget(RdTarget),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqTarget(ReqTarget),
        .ResValid(ResValid), .ResReady(ResReady), .ResAddr(ResAddr), .ResHit(ResHit)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_vld[i]  = 0;
            m_data[i] = '0;
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit clr);
        WrEn = 1'b1; WrAddr = a; WrData = d; Clear = clr;
        tick();
        WrEn = 1'b0; Clear = 1'b0;
        if (clr) for (int i = 0; i < DEPTH; i++) m_vld[i] = 0;
        m_data[a] = d;
        m_vld[a]  = 1;
    endtask

    task automatic rd_chk(input logic [AW-1:0] a);
        RdAddr = a;
        #1;
        chk($sformatf("rdback[%0d]", a), RdTarget, m_vld[a] ? m_data[a] : '0);
    endtask

    // Search with an optional write issued during scan cycle wc (cycle c is the
    // one comparing index c). Entry i is compared at the end of cycle i, so the
    // written value is visible to indices strictly above wc only.
    task automatic search(input logic [DW-1:0] t, input bit mid_wr, input int wc,
                          input logic [AW-1:0] wa, input logic [DW-1:0] wd, input int hold);
        bit            e_hit = 0;
        logic [AW-1:0] e_addr = '0;
        int            e_lat = DEPTH;
        int            cyc;
        bit            issued = 0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [DW-1:0] d = m_data[i];
            bit            v = m_vld[i];
            if (mid_wr && i > wc && i == int'(wa)) begin d = wd; v = 1; end
            if (v && d == t) begin
                e_hit = 1; e_addr = AW'(i); e_lat = i + 1;
                break;
            end
        end
        chk("req_ready_idle", ReqReady, 1);
        ReqValid = 1'b1; ReqTarget = t;
        tick();
        ReqValid = 1'b0;
        chk("req_ready_busy", ReqReady, 0);
        cyc = 0;
        while (!ResValid && cyc < 40) begin
            if (mid_wr && cyc == wc) begin
                WrEn = 1'b1; WrAddr = wa; WrData = wd; issued = 1;
            end
            tick();
            WrEn = 1'b0;
            cyc++;
        end
        if (issued) begin m_data[wa] = wd; m_vld[wa] = 1; end
        chk("latency", cyc, e_lat);
        chk("res_hit", ResHit, e_hit);
        chk("res_addr", ResAddr, e_addr);
        // Hold the result; a request arriving now must be ignored.
        for (int h = 0; h < hold; h++) begin
            ReqValid = 1'b1; ReqTarget = ~t;
            tick();
            chk("hold_valid", ResValid, 1);
            chk("hold_addr", ResAddr, e_addr);
            chk("hold_hit", ResHit, e_hit);
            chk("hold_req_ready", ReqReady, 0);
        end
        ReqValid = 1'b0;
        ResReady = 1'b1;
        tick();
        ResReady = 1'b0;
        chk("consumed_valid", ResValid, 0);
        chk("back_idle", ReqReady, 1);
    endtask

    initial begin
        Reset_n = 1'b0; Clear = 1'b0; WrEn = 1'b0; WrAddr = '0; WrData = '0;
        RdAddr = '0; ReqValid = 1'b0; ReqTarget = '0; ResReady = 1'b0;
        model_clear();
        #12;
        chk("rst_req_ready", ReqReady, 1);
        chk("rst_res_valid", ResValid, 0);
        chk("rst_res_addr", ResAddr, 0);
        chk("rst_res_hit", ResHit, 0);
        Reset_n = 1'b1;
        tick();

        // 1: empty table readback and miss
        for (int i = 0; i < DEPTH; i += 5) rd_chk(AW'(i));
        search(10'h000, 0, 0, '0, '0, 0);

        // 2: simple hit
        wr(4'd1, 10'h009, 0);
        wr(4'd2, 10'h06D, 0);
        wr(4'd3, 10'h001, 0);
        for (int i = 0; i < DEPTH; i++) rd_chk(AW'(i));
        search(10'h06D, 0, 0, '0, '0, 0);

        // 3: duplicate targets, lowest wins, result held under backpressure
        wr(4'd5, 10'h1A5, 0);
        wr(4'd9, 10'h1A5, 0);
        search(10'h1A5, 0, 0, '0, '0, 4);

        // 4: writes during scan ahead of / behind the pointer
        search(10'h3FF, 1, 1, 4'd7, 10'h3FF, 0);
        wr(4'd7, 10'h000, 0);
        search(10'h3FF, 1, 1, 4'd0, 10'h3FF, 0);

        // 5: Clear together with a write
        wr(4'd4, 10'h009, 1);
        rd_chk(4'd1);
        rd_chk(4'd4);
        search(10'h009, 0, 0, '0, '0, 0);

        // 6: reset mid-scan
        ReqValid = 1'b1; ReqTarget = 10'h2AA;
        tick();
        ReqValid = 1'b0;
        tick(); tick();
        Reset_n = 1'b0;
        #1;
        chk("midrst_res_valid", ResValid, 0);
        chk("midrst_req_ready", ReqReady, 1);
        model_clear();
        for (int i = 0; i < DEPTH; i++) rd_chk(AW'(i));
        #2;
        Reset_n = 1'b1;
        tick();

        // Randomized loads and searches over a narrow value range to force collisions
        for (int r = 0; r < 30; r++) begin
            int nw = $urandom_range(0, 3);
            for (int k = 0; k < nw; k++)
                wr(AW'($urandom_range(0, DEPTH - 1)), DW'($urandom_range(0, 7)),
                   ($urandom_range(0, 9) == 0));
            rd_chk(AW'($urandom_range(0, DEPTH - 1)));
            search(DW'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
                   $urandom_range(0, DEPTH - 1), AW'($urandom_range(0, DEPTH - 1)),
                   DW'($urandom_range(0, 7)), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/target_encoder.md
Name: target_encoder

Overview:
- Reverse of the branch-target lookup. The lookup maps a 4-bit pointer to a 10-bit PC target; this block maps a 10-bit target back to the lowest 4-bit pointer that holds it.
- It holds a writable 16-entry target table, so the table contents can be loaded at run time rather than hard-coded.
- It serves the assembler/loader path and branch-pointer allocation next to the fetch stage.
- A search runs sequentially: one entry is compared per cycle, with valid/ready handshakes on both the request side and the result side.

Parameters:
- DEPTH, 16, number of table entries (power of 2).
- AW, 4, pointer width, equal to log2(DEPTH).
- DW, 10, target width, matching the PC target width.

Ports:
- Clk, input, 1, rising-edge clock.
- Reset_n, input, 1, asynchronous active-low reset.
- Clear, input, 1, synchronous invalidate of all table entries.
- WrEn, input, 1, table write strobe.
- WrAddr, input, AW, entry to write.
- WrData, input, DW, target value to store.
- RdAddr, input, AW, combinational readback index.
- RdTarget, output, DW, stored target at RdAddr; 0 if that entry is invalid.
- ReqValid, input, 1, search request valid.
- ReqReady, output, 1, block can accept a request.
- ReqTarget, input, DW, target value to search for.
- ResValid, output, 1, a result is available.
- ResReady, input, 1, consumer accepts the result.
- ResAddr, output, AW, lowest matching index (0 on miss).
- ResHit, output, 1, 1 if a match was found.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - All entry valid bits = 0; entry data = 0.
  - FSM = IDLE, so ReqReady = 1.
  - ResValid = 0, ResAddr = 0, ResHit = 0.
  - Scan pointer = 0; latched target = 0.
- Reset mid-search aborts the search; no result is produced.
- Table write:
  - When WrEn = 1, at the clock edge entry[WrAddr] takes WrData and its valid bit is set.
  - Clear = 1 resets every valid bit. If Clear and WrEn are both asserted in the same cycle, Clear applies first and then the write, so only WrAddr ends up valid.
- Readback: RdTarget is purely combinational with zero latency and is unaffected by the FSM.
- FSM states: IDLE, SCAN, DONE.
  - IDLE:
    - ReqReady = 1.
    - On ReqValid, latch ReqTarget, set pointer = 0, go to SCAN.
  - SCAN:
    - ReqReady = 0.
    - Each cycle, compare entry[pointer] (valid and data == latched target) using the current registered contents.
    - On a match: ResAddr = pointer, ResHit = 1, go to DONE.
    - Else if pointer == DEPTH-1: ResAddr = 0, ResHit = 0, go to DONE.
    - Else pointer += 1. The pointer never wraps.
  - DONE:
    - ResValid = 1; ResAddr and ResHit are held stable.
    - ReqReady = 0.
    - On ResReady, ResValid drops to 0 at the edge and the FSM returns to IDLE.
    - A new request can be accepted no earlier than the cycle after the result is consumed.
- Latency, counted from the accepting edge:
  - Hit at index i: ResValid is high starting i+1 cycles after that edge.
  - Miss: ResValid is high DEPTH cycles after that edge.
- Multiple matches: the lowest index wins (early exit).
- Writes during SCAN:
  - They are allowed and take effect normally.
  - A write to an index greater than the current pointer is seen by this search.
  - A write to an index at or below the current pointer is not seen.
  - Clear during SCAN behaves the same way: entries not yet compared appear invalid.
- Writes and Clear during DONE do not alter the result already held.
- ReqValid while the block is busy is ignored; the requester must hold it until ReqReady.
- Comparisons are exact, full DW-bit equality. Data in invalid entries never matches.

Test Plan:
1. Reset, then readback of any RdAddr → RdTarget = 0. A search for 0 → miss: ResHit = 0, ResAddr = 0, ResValid high 16 cycles after the accepting edge.
2. Write entry1 = 0x009, entry2 = 0x06D, entry3 = 0x001. Search 0x06D → ResHit = 1, ResAddr = 2, ResValid high 3 cycles after the accepting edge.
3. Write 0x1A5 to entries 5 and 9. Search 0x1A5 → ResAddr = 5. Hold ResReady = 0 for 4 cycles → outputs stay stable and ReqReady stays 0. Assert ResReady → back to IDLE the next cycle.
4. Search 0x3FF. At the second SCAN cycle write entry7 = 0x3FF → hit at ResAddr = 7. Repeat with the write to entry0 during SCAN → miss.
5. Assert Clear together with WrEn (WrAddr = 4, WrData = 0x009). Search 0x009 → ResAddr = 4, and the earlier entry1 no longer matches.
6. Drop Reset_n mid-SCAN → ResValid = 0 and ReqReady = 1 immediately, and the table is empty afterwards.
